uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame geometry and line levels.
// The transmitter imports the same constants so both ends agree on the frame format.
package uart_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_OVERSAMPLE = 16;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous serial line; resets to the idle line level.
module uart_sync2
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= IDLE_LEVEL;
         q    <= IDLE_LEVEL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch reject, mid-bit sampling, one-entry
// valid/ready output holding register with framing and overrun error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  baud_x16_en,
   input  logic                  Rx_data,
   output logic [DATA_WIDTH-1:0] m_axis_data,
   output logic                  m_axis_valid,
   input  logic                  m_axis_ready,
   output logic                  frame_err,
   output logic                  overrun_err,
   output uart_state_e           fsm_state
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   uart_state_e           state, state_n;
   logic [TW-1:0]         tick_cnt, tick_n;
   logic [BW-1:0]         bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic                  rx_s;
   logic                  rx_prev;
   logic                  deliver;
   logic                  bad_stop;

   uart_sync2 u_sync (
      .clk   (i_clk),
      .rst_n (i_rst),
      .d     (Rx_data),
      .q     (rx_s)
   );

   assign fsm_state = state;

   // rx_prev is the line value at the previous oversample tick, so edge detection
   // freezes with the FSM and a line held low after a bad stop bit never restarts.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         rx_prev  <= 1'b1;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         bit_cnt  <= bit_n;
         shift    <= shift_n;
         if (baud_x16_en) rx_prev <= rx_s;
      end
   end

   always_comb begin
      state_n  = state;
      tick_n   = tick_cnt;
      bit_n    = bit_cnt;
      shift_n  = shift;
      deliver  = 1'b0;
      bad_stop = 1'b0;
      if (baud_x16_en) begin
         unique case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  tick_n  = '0;
                  state_n = START;
               end
            end
            START: begin
               if (tick_cnt == TICK_HALF) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  state_n = (rx_s == START_BIT) ? DATA : IDLE;
               end else begin
                  tick_n = tick_cnt + TW'(1);
               end
            end
            DATA: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_n  = '0;
                  shift_n = {rx_s, shift[DATA_WIDTH-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     bit_n   = '0;
                     state_n = STOP;
                  end else begin
                     bit_n = bit_cnt + BW'(1);
                  end
               end else begin
                  tick_n = tick_cnt + TW'(1);
               end
            end
            STOP: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_n   = '0;
                  state_n  = IDLE;
                  deliver  = (rx_s == STOP_BIT);
                  bad_stop = (rx_s != STOP_BIT);
               end else begin
                  tick_n = tick_cnt + TW'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Handshake: a beat transfers on any edge where m_axis_valid && m_axis_ready;
   // data is held stable while valid && !ready, and valid never drops without a transfer.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         m_axis_data  <= '0;
         m_axis_valid <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         frame_err   <= bad_stop;
         overrun_err <= deliver && m_axis_valid && !m_axis_ready;
         if (deliver && (!m_axis_valid || m_axis_ready)) begin
            m_axis_data  <= shift;
            m_axis_valid <= 1'b1;
         end else if (m_axis_valid && m_axis_ready) begin
            m_axis_valid <= 1'b0;
         end
      end
   end

endmodule
